// File: rtl/ram4_bank.sv
// Four-word register bank fed by a 4-way load demux, with a 4-edge zero-fill sweep and a
// registered read port. Optional per-word parity is enabled with RAM4_BANK_PARITY_EN.
module ram4_bank #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [1:0]       address,
    input  logic             clear,
    input  logic             par_inject,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             parity_err
);

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       clr_ptr_q, clr_ptr_d;
    logic             load_a, load_b, load_c, load_d;
    logic [3:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] mem_q [4];
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;

    assign load_a = load & (address == 2'd0);
    assign load_b = load & (address == 2'd1);
    assign load_c = load & (address == 2'd2);
    assign load_d = load & (address == 2'd3);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_sel    = '0;
        wr_data   = in;
        unique case (state_q)
            StClear: begin
                wr_sel    = 4'b0001 << clr_ptr_q;
                wr_data   = '0;
                clr_ptr_d = clr_ptr_q + 2'd1;
                if (clr_ptr_q == 2'd3) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A clear request drops any load presented on the same edge.
                if (clear) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end else begin
                    wr_sel = {load_d, load_c, load_b, load_a};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StClear;
            clr_ptr_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            if (state_q == StRun) begin
                out_q       <= mem_q[address];
                out_valid_q <= 1'b1;
            end else begin
                out_q       <= '0;
                out_valid_q <= 1'b0;
            end
        end
    end

    // Contents are left alone on the reset edge; the following sweep zeroes them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_sel[k]) begin
                    mem_q[k] <= wr_data;
                end
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == StClear);

`ifdef RAM4_BANK_PARITY_EN
    logic par_q [4];
    logic wr_par;
    logic perr_q;

    assign wr_par = (state_q == StRun) ? (^in ^ par_inject) : 1'b0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_sel[k]) begin
                    par_q[k] <= wr_par;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (state_q == StRun) begin
            perr_q <= (^mem_q[address]) != par_q[address];
        end else begin
            perr_q <= 1'b0;
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram4_bank.sv
// Table-driven bench for ram4_bank: each vector's expected post-edge outputs go into a
// scoreboard queue when driven and are popped and compared after the edge.
module tb_ram4_bank;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        load;
    logic [1:0]  address;
    logic        clear;
    logic        par_inject;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;
    logic        parity_err;

`ifdef RAM4_BANK_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    ram4_bank #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .load      (load),
        .address   (address),
        .clear     (clear),
        .par_inject(par_inject),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [1:0]  adr;
        logic [15:0] d;
        logic        clr;
        logic        inj;
        logic [15:0] eout;
        logic        evld;
        logic        ebusy;
        logic        eperr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] eout;
        logic        evld;
        logic        ebusy;
        logic        eperr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic add(input logic rst, input logic ld, input logic [1:0] adr,
                       input logic [15:0] d, input logic clr, input logic inj,
                       input logic [15:0] eout, input logic evld, input logic ebusy,
                       input logic eperr);
        vec_t v;
        v = '{rst, ld, adr, d, clr, inj, eout, evld, ebusy, eperr};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got out/vld/busy/perr=%h required %h", name, act, exp);
    endtask

    initial begin
        exp_t e;
        int   n;
        reset = 1'b0; load = 1'b0; address = 2'd0; din = '0; clear = 1'b0; par_inject = 1'b0;

        //   rst ld adr  din       clr inj  out      vld busy perr
        // Reset and 4-edge sweep, then all words read zero.
        add(1, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd1, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd3, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        // Write BEEF to word 2; other words stay zero.
        add(0, 1, 2'd2, 16'hBEEF, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd1, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd3, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        // Read-before-write on word 1.
        add(0, 1, 2'd1, 16'h0001, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 1, 2'd1, 16'h1234, 0, 0, 16'h0001, 1, 0, 0);
        add(0, 0, 2'd1, 16'h0000, 0, 0, 16'h1234, 1, 0, 0);
        // clear beats load; load and clear during the sweep are ignored.
        add(0, 1, 2'd0, 16'h5A5A, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h5A5A, 1, 0, 0);
        add(0, 1, 2'd0, 16'hFFFF, 1, 0, 16'h5A5A, 1, 1, 0);
        add(0, 1, 2'd3, 16'h7777, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd1, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd3, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        // Reset in RUN (priority over load), then reset again two edges into the sweep.
        add(0, 1, 2'd2, 16'hCAFE, 0, 0, 16'h0000, 1, 0, 0);
        add(1, 1, 2'd2, 16'h1111, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(1, 1, 2'd2, 16'h2222, 1, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 2'd2, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        // Parity: 00F0 has even weight, so an injected bit shows as an error.
        add(0, 1, 2'd3, 16'h00F0, 0, 1, 16'h0000, 1, 0, 0);
        add(0, 0, 2'd3, 16'h0000, 0, 0, 16'h00F0, 1, 0, PAR);
        add(0, 1, 2'd3, 16'h00F0, 0, 0, 16'h00F0, 1, 0, PAR);
        add(0, 0, 2'd3, 16'h0000, 0, 0, 16'h00F0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; load = vecs[i].ld; address = vecs[i].adr;
            din = vecs[i].d; clear = vecs[i].clr; par_inject = vecs[i].inj;
            sb.push_back('{i, vecs[i].eout, vecs[i].evld, vecs[i].ebusy, vecs[i].eperr});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", e.idx), {out, out_valid, busy, parity_err},
                  {e.eout, e.evld, e.ebusy, e.eperr});
        end

        // Count edges from reset release until busy falls, bounded.
        reset = 1'b1; load = 1'b0; clear = 1'b0; address = 2'd1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n == 4) passed++;
        else $display("FAIL busy_len: got %0d edges required 4", n);
        total++;
        if (out_valid === 1'b0) passed++;
        else $display("FAIL vld_at_busy_fall: got %b required 0", out_valid);
        @(posedge clk);
        #1;
        total++;
        if (out_valid === 1'b1 && out === 16'h0000) passed++;
        else $display("FAIL vld_rise: got vld=%b out=%h required vld=1 out=0000", out_valid, out);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
